clk_div: RTL and testbench

- Parametrised multi-channel clock divider; successor to the fixed divide-by-2 generator.
- Produces CH independent divided clocks from one source clock.
- Each channel has:
  - a runtime-programmable divide ratio, switched glitch-free;
  - a per-channel enable;
  - a one-cycle strobe at each divided-clock rising edge.
- A common sync pulse phase-aligns all channels. Sits at TOP level and feeds PHY/MAC timing domains and clock-enable users.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_ch.sv | 49 ++++
 rtl/clk_div.sv | 29 ++
 tb/tb_clk_div.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int          CNT_W_DEF = 8;
  localparam int unsigned DIV_MIN   = 2;

  // Ratios below DIV_MIN cannot form a high and a low phase, so they clamp.
  function automatic int unsigned eff_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  function automatic int unsigned hi_len(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, latched ratio, and registered clock/strobe.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div,
  output logic             dclk,
  output logic             stb
);

  logic [CNT_W-1:0] cnt, dact, cnt_nxt;
  logic             run, wrap;

  assign cnt_nxt = cnt + 1'b1;
  assign wrap    = (cnt == dact - 1'b1);

  // Ratio is only reloaded at a period boundary, so a mid-period change can
  // never shorten or stretch the period in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dact <= '0;
      run  <= 1'b0;
      dclk <= 1'b0;
      stb  <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      run  <= 1'b0;
      dclk <= 1'b0;
      stb  <= 1'b0;
    end else if (!run || sync || wrap) begin
      cnt  <= '0;
      dact <= CNT_W'(eff_div(32'(div)));
      run  <= 1'b1;
      dclk <= 1'b1;
      stb  <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      dclk <= (32'(cnt_nxt) < hi_len(32'(dact)));
      stb  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div.sv
// CH independent glitch-free clock dividers sharing one source clock and sync.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk_clk_div,
  input  logic                rst_clk_div,
  input  logic [CH-1:0]       en_i,
  input  logic [CH*CNT_W-1:0] div_i,
  input  logic                sync_i,
  output logic [CH-1:0]       clk_o,
  output logic [CH-1:0]       stb_o
);

  for (genvar n = 0; n < CH; n++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk_clk_div),
      .rst_n (rst_clk_div),
      .en    (en_i[n]),
      .sync  (sync_i),
      .div   (div_i[n*CNT_W +: CNT_W]),
      .dclk  (clk_o[n]),
      .stb   (stb_o[n])
    );
  end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: elapsed-time reference model plus literal waveform checks.
module tb_clk_div;
  localparam int CH = 4, CNT_W = 8;

  logic                clk = 1'b0, rst = 1'b1, sync = 1'b0, go = 1'b0;
  logic [CH-1:0]       en = '0;
  logic [CH*CNT_W-1:0] div = '0;
  logic [CH-1:0]       clk_o, stb_o;
  int errors = 0, checks = 0;

  clk_div #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk_clk_div(clk), .rst_clk_div(rst), .en_i(en), .div_i(div),
    .sync_i(sync), .clk_o(clk_o), .stb_o(stb_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setdiv(input int n, input int d);
    div[n*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  // Model: each channel remembers when its current period started and how long it is.
  bit          m_run [CH];
  int          m_ps  [CH];
  int          m_d   [CH];
  int          t = 0, md;
  logic [CH-1:0] exp_clk = '0, exp_stb = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < CH; n++) m_run[n] = 0;
      exp_clk = '0;
      exp_stb = '0;
    end else begin
      t++;
      for (int n = 0; n < CH; n++) begin
        md = int'(div[n*CNT_W +: CNT_W]);
        if (!en[n]) m_run[n] = 0;
        else if (!m_run[n] || sync || (t - m_ps[n]) == m_d[n]) begin
          m_run[n] = 1;
          m_ps[n]  = t;
          m_d[n]   = (md < 2) ? 2 : md;
        end
        exp_clk[n] = m_run[n] && ((t - m_ps[n]) < (m_d[n] + 1) / 2);
        exp_stb[n] = m_run[n] && (t == m_ps[n]);
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("model_clk", 32'(clk_o), 32'(exp_clk));
      chk("model_stb", 32'(stb_o), 32'(exp_stb));
    end
  end

  bit p2c [4]  = '{1, 0, 1, 0};
  bit p5c [5]  = '{1, 1, 1, 0, 0};
  bit p5s [5]  = '{1, 0, 0, 0, 0};
  bit p46 [10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
  bit p7c [6]  = '{1, 1, 1, 0, 0, 0};

  initial begin
    #1 rst = 1'b0;
    go = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_clk", 32'(clk_o), 32'h0);
    chk("reset_stb", 32'(stb_o), 32'h0);
    rst = 1'b1;

    // divide by 2 on ch0
    setdiv(0, 2); en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d2_clk", 32'(clk_o[0]), 32'(p2c[i]));
      chk("d2_stb", 32'(stb_o[0]), 32'(p2c[i]));
    end

    // divide by 5 on ch1, 20 periods
    setdiv(1, 5); en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d5_clk", 32'(clk_o[1]), 32'(p5c[i]));
      chk("d5_stb", 32'(stb_o[1]), 32'(p5s[i]));
    end
    repeat (95) @(negedge clk);

    // ch2: ratio 4 -> 6 changed mid-period
    setdiv(2, 4); en[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("d4to6_clk", 32'(clk_o[2]), 32'(p46[i]));
      if (i == 4) chk("d4to6_stb", 32'(stb_o[2]), 32'h1);
      if (i == 1) setdiv(2, 6);
    end

    // sync aligns ch0 (3) and ch1 (4); ch3 disabled
    en = '0; @(negedge clk);
    setdiv(0, 3); setdiv(1, 4); en = 4'b0011;
    repeat (7) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_clk", 32'(clk_o[1:0]), 32'h3);
    chk("sync_stb", 32'(stb_o[1:0]), 32'h3);
    chk("sync_off", 32'(clk_o[3]), 32'h0);
    repeat (5) @(negedge clk);
    sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("synch_clk", 32'(clk_o[1:0]), 32'h3);
      chk("synch_stb", 32'(stb_o[1:0]), 32'h3);
    end
    sync = 1'b0;
    repeat (12) @(negedge clk);

    // ratios 0 and 1 clamp to 2; enable dropped in high phase
    en = '0; @(negedge clk);
    setdiv(0, 0); setdiv(1, 1); en = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d0_clk", 32'(clk_o[0]), 32'(p2c[i]));
      chk("d1_clk", 32'(clk_o[1]), 32'(p2c[i]));
    end
    @(negedge clk);
    chk("pre_drop", 32'(clk_o[1]), 32'h1);
    en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop_clk", 32'(clk_o[1]), 32'h0);
    end

    // async reset between edges, then restart with ratio 7
    setdiv(0, 7);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_o), 32'h0);
    chk("arst_stb", 32'(stb_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_clk", 32'(clk_o[0]), 32'h1);
    chk("rel_stb", 32'(stb_o[0]), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d7_clk", 32'(clk_o[0]), 32'(p7c[i]));
    end

    // maximum ratio on ch3 alongside ch0
    setdiv(3, 255); en = 4'b1001;
    repeat (520) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
